// File: rtl/insn_queue_if.sv
// Fetch-to-decode handshake bundle for insn_queue: enqueue side, dequeue side,
// flush and occupancy. The slave modport is the queue; master is the pipeline around it.
interface insn_queue_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              enq_valid_i;
  logic [AWIDTH-1:0] enq_pc_i;
  logic [DWIDTH-1:0] enq_insn_i;
  logic              enq_ready_o;
  logic              deq_valid_o;
  logic [AWIDTH-1:0] deq_pc_o;
  logic [DWIDTH-1:0] deq_insn_o;
  logic              deq_ready_i;
  logic [CW-1:0]     count_o;

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_insn_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_insn_o, count_o
  );

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_insn_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_insn_o, count_o
  );
endinterface

// File: rtl/insn_queue.sv
// Circular instruction queue between fetch and decode with flush support.
// Define INSN_QUEUE_BYPASS_EN to pass an entry offered to an empty queue straight to decode.
module insn_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  insn_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DWIDTH-1:0] INSN_NOP = DWIDTH'(32'h0000_0013);

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic              full;
  logic              stored_valid;
  logic              bypass_act;
  logic              deq_valid;
  logic [AWIDTH-1:0] head_pc;
  logic [DWIDTH-1:0] head_insn;
  logic              do_enq;
  logic              do_deq;
  logic              bypass_take;
  logic              wr_en;
  logic              rd_adv;

  assign full         = (count == CW'(DEPTH));
  assign stored_valid = (count != '0) && !bus.flush_i;

`ifdef INSN_QUEUE_BYPASS_EN
  assign bypass_act = !rst && (count == '0) && bus.enq_valid_i && !bus.flush_i;
`else
  assign bypass_act = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    deq_valid = 1'b0;
    head_pc   = '0;
    head_insn = INSN_NOP;
    if (stored_valid) begin
      deq_valid = 1'b1;
      head_pc   = pc_mem[rd_ptr];
      head_insn = insn_mem[rd_ptr];
    end else if (bypass_act) begin
      deq_valid = 1'b1;
      head_pc   = bus.enq_pc_i;
      head_insn = bus.enq_insn_i;
    end
  end

  assign do_enq      = bus.enq_valid_i && !full && !bus.flush_i;
  assign do_deq      = deq_valid && bus.deq_ready_i && !bus.flush_i;
  // A bypassed entry consumed in the same cycle never touches storage or pointers.
  assign bypass_take = bypass_act && bus.deq_ready_i;
  assign wr_en       = do_enq && !bypass_take;
  assign rd_adv      = do_deq && !bypass_take;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= bus.enq_pc_i;
      insn_mem[wr_ptr] <= bus.enq_insn_i;
    end
  end

  assign bus.enq_ready_o = !full;
  assign bus.deq_valid_o = deq_valid;
  assign bus.deq_pc_o    = head_pc;
  assign bus.deq_insn_o  = head_insn;
  assign bus.count_o     = count;
endmodule

// File: tb/tb_insn_queue.sv
// Directed self-checking bench for insn_queue (DEPTH = 4); follows INSN_QUEUE_BYPASS_EN
// to choose same-cycle or one-cycle-later expectations.
module tb_insn_queue;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  insn_queue_if #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP)) bus ();

  insn_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 more unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] insn);
    bus.enq_valid_i = v;
    bus.enq_pc_i    = pc;
    bus.enq_insn_i  = insn;
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.deq_ready_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset then idle
    check("rst_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check("rst_deq_insn",  64'(bus.deq_insn_o),  64'h13);
    check("rst_deq_pc",    64'(bus.deq_pc_o),    64'h0);
    check("rst_enq_ready", 64'(bus.enq_ready_o), 64'd1);
    check("rst_count",     64'(bus.count_o),     64'd0);

    // Fill four entries with decode stalled
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h0100_0000 + 32'(4 * i), 32'h0000_0100 + 32'(i));
      tick();
    end
    offer(1'b1, 32'h0100_0010, 32'h0000_0104);
    settle();
    check("fill_count",     64'(bus.count_o),     64'd4);
    check("fill_enq_ready", 64'(bus.enq_ready_o), 64'd0);
    check("fill_head_pc",   64'(bus.deq_pc_o),    64'h0100_0000);
    tick();
    check("fifth_refused_count", 64'(bus.count_o),  64'd4);
    check("fifth_head_pc",       64'(bus.deq_pc_o), 64'h0100_0000);
    check("fifth_head_insn",     64'(bus.deq_insn_o), 64'h100);

    // Full with simultaneous dequeue: enqueue still refused
    bus.deq_ready_i = 1'b1;
    tick();
    check("full_deq_count", 64'(bus.count_o), 64'd3);
    offer(1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      settle();
      check("drain_pc", 64'(bus.deq_pc_o), 64'h0100_0000 + 64'(4 * i));
      tick();
    end
    check("drain_count",     64'(bus.count_o),     64'd0);
    check("drain_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check("drain_deq_insn",  64'(bus.deq_insn_o),  64'h13);

    // Streaming six entries across pointer wrap
    for (int k = 0; k < 6; k++) begin
      offer(1'b1, 32'h0100_0200 + 32'(4 * k), 32'h0000_0200 + 32'(k));
`ifdef INSN_QUEUE_BYPASS_EN
      settle();
      check("stream_pc",    64'(bus.deq_pc_o),    64'h0100_0200 + 64'(4 * k));
      check("stream_valid", 64'(bus.deq_valid_o), 64'd1);
      tick();
      check("stream_count", 64'(bus.count_o), 64'd0);
`else
      tick();
      check("stream_count", 64'(bus.count_o),  64'd1);
      check("stream_pc",    64'(bus.deq_pc_o), 64'h0100_0200 + 64'(4 * k));
`endif
    end
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_end_count", 64'(bus.count_o), 64'd0);

    // Mid-stream flush with a same-cycle enqueue that must be dropped
    bus.deq_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h0100_0300 + 32'(4 * i), 32'h0000_0300 + 32'(i));
      tick();
    end
    check("pre_flush_count", 64'(bus.count_o), 64'd3);
    bus.flush_i = 1'b1;
    offer(1'b1, 32'h0100_0100, 32'h0000_0999);
    settle();
    check("flush_deq_valid_now", 64'(bus.deq_valid_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    settle();
    check("flush_count",     64'(bus.count_o),     64'd0);
    check("flush_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check("flush_enq_ready", 64'(bus.enq_ready_o), 64'd1);
    offer(1'b1, 32'h0100_0400, 32'h0000_0400);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    settle();
    check("post_flush_head", 64'(bus.deq_pc_o), 64'h0100_0400);
    check("post_flush_cnt",  64'(bus.count_o),  64'd1);
    bus.deq_ready_i = 1'b1;
    tick();
    check("post_flush_empty", 64'(bus.count_o), 64'd0);

    // Empty-queue latency: same cycle with bypass, one cycle later without
    offer(1'b1, 32'h0100_0500, 32'h0050_0093);
    settle();
`ifdef INSN_QUEUE_BYPASS_EN
    check("bypass_insn_now",  64'(bus.deq_insn_o),  64'h0050_0093);
    check("bypass_valid_now", 64'(bus.deq_valid_o), 64'd1);
    tick();
    check("bypass_count", 64'(bus.count_o), 64'd0);
    offer(1'b0, 32'h0, 32'h0);
`else
    check("nobypass_valid_now", 64'(bus.deq_valid_o), 64'd0);
    check("nobypass_insn_now",  64'(bus.deq_insn_o),  64'h13);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    settle();
    check("nobypass_insn_next", 64'(bus.deq_insn_o), 64'h0050_0093);
    check("nobypass_count",     64'(bus.count_o),    64'd1);
    tick();
    check("nobypass_drained", 64'(bus.count_o), 64'd0);
`endif

    // Reset mid-operation wins over a concurrent enqueue
    bus.deq_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h0100_0600 + 32'(4 * i), 32'h0000_0600);
      tick();
    end
    check("pre_rst_count", 64'(bus.count_o), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    settle();
    check("midrst_count",     64'(bus.count_o),     64'd0);
    check("midrst_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check("midrst_deq_pc",    64'(bus.deq_pc_o),    64'h0);
    check("midrst_enq_ready", 64'(bus.enq_ready_o), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
